// File: rtl/dcache_pkg.sv
// Shared definitions for the write-back data cache: FSM encoding, default
// geometry and helpers that derive address-field widths from the parameters.
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_REFILL    = 2'd2
  } state_e;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_SETS       = 64;
  localparam int DEF_ADDR_W     = 32;

  function automatic int byte_off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int word_off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int data_w,
                               input int line_words, input int sets);
    return addr_w - byte_off_w(data_w) - word_off_w(line_words) - index_w(sets);
  endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// Per-set valid/dirty/tag storage: combinational lookup, one write port.
// Valid and dirty clear on reset; tags are left as they are.
module dcache_tag_array
  import dcache_pkg::*;
#(
  parameter int SETS  = DEF_SETS,
  parameter int IDX_W = 6,
  parameter int TAG_W = 22
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] lk_idx,
  output logic             lk_valid,
  output logic             lk_dirty,
  output logic [TAG_W-1:0] lk_tag,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_dirty,
  input  logic [TAG_W-1:0] wr_tag
);

  logic [SETS-1:0]  valid_q, valid_d;
  logic [SETS-1:0]  dirty_q, dirty_d;
  logic [TAG_W-1:0] tag_q [SETS];

  // Every write installs or touches a resident line, so it always sets valid.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      dirty_d[wr_idx] = wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
    if (wr_en && !reset) tag_q[wr_idx] <= wr_tag;
  end

  assign lk_valid = valid_q[lk_idx];
  assign lk_dirty = dirty_q[lk_idx];
  assign lk_tag   = tag_q[lk_idx];

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back data cache with a line-wide memory port.
// Hits are zero-latency; misses stall while evicting and refilling.
module dcache_wb
  import dcache_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int SETS       = DEF_SETS,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         re,
  input  logic                         we,
  input  logic [DATA_W/8-1:0]          be,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            rdata,
  output logic                         stall,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [LINE_WORDS*DATA_W-1:0] mem_wdata,
  input  logic [LINE_WORDS*DATA_W-1:0] mem_rdata,
  input  logic                         mem_ready,
  output logic [1:0]                   dbg_state
);

  localparam int BYTES      = DATA_W / 8;
  localparam int BO_W       = byte_off_w(DATA_W);
  localparam int WO_W       = word_off_w(LINE_WORDS);
  localparam int IDX_W      = index_w(SETS);
  localparam int TAG_W      = tag_w(ADDR_W, DATA_W, LINE_WORDS, SETS);
  localparam int LINE_OFF_W = BO_W + WO_W;
  localparam int LINE_W     = LINE_WORDS * DATA_W;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [LINE_W-1:0]   data_q [SETS];

  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    req_idx;
  logic [WO_W-1:0]     req_woff;
  logic                lk_valid, lk_dirty;
  logic [TAG_W-1:0]    lk_tag;
  logic                access, hit, store_hit, refill_done;
  logic [LINE_W-1:0]   hit_line, line_wr_data;
  logic                line_wr_en;
  logic                unused_byte_off;

  assign req_tag         = addr[ADDR_W-1 -: TAG_W];
  assign req_idx         = addr[LINE_OFF_W +: IDX_W];
  assign req_woff        = addr[BO_W +: WO_W];
  assign unused_byte_off = ^addr[BO_W-1:0];

  dcache_tag_array #(
    .SETS (SETS),
    .IDX_W(IDX_W),
    .TAG_W(TAG_W)
  ) u_tags (
    .clk     (clk),
    .reset   (reset),
    .lk_idx  (req_idx),
    .lk_valid(lk_valid),
    .lk_dirty(lk_dirty),
    .lk_tag  (lk_tag),
    .wr_en   (line_wr_en & ~reset),
    .wr_idx  (req_idx),
    .wr_dirty(store_hit),
    .wr_tag  (req_tag)
  );

  // Lookups only count as hits in IDLE; a replay retries once the refill lands.
  assign access      = re | we;
  assign hit         = (state_q == ST_IDLE) & access & lk_valid & (lk_tag == req_tag);
  assign store_hit   = hit & we;
  assign refill_done = (state_q == ST_REFILL) & mem_ready;
  assign hit_line    = data_q[req_idx];
  assign rdata       = (hit & re & ~we) ? hit_line[req_woff*DATA_W +: DATA_W] : '0;
  assign stall       = (state_q != ST_IDLE) | (access & ~hit);

  always_comb begin
    line_wr_en   = 1'b0;
    line_wr_data = hit_line;
    if (refill_done) begin
      line_wr_en   = 1'b1;
      line_wr_data = mem_rdata;
    end else if (store_hit) begin
      line_wr_en = 1'b1;
      for (int b = 0; b < BYTES; b++) begin
        if (be[b]) line_wr_data[req_woff*DATA_W + b*8 +: 8] = wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (line_wr_en && !reset) data_q[req_idx] <= line_wr_data;
  end

  // Memory-side outputs are loaded on state entry and held until mem_ready.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (access && !hit) begin
          mem_req_d = 1'b1;
          if (lk_valid && lk_dirty) begin
            state_d     = ST_WRITEBACK;
            mem_we_d    = 1'b1;
            mem_addr_d  = {lk_tag, req_idx, {LINE_OFF_W{1'b0}}};
            mem_wdata_d = hit_line;
          end else begin
            state_d     = ST_REFILL;
            mem_we_d    = 1'b0;
            mem_addr_d  = {req_tag, req_idx, {LINE_OFF_W{1'b0}}};
            mem_wdata_d = '0;
          end
        end
      end
      ST_WRITEBACK: begin
        if (mem_ready) begin
          state_d     = ST_REFILL;
          mem_we_d    = 1'b0;
          mem_addr_d  = {req_tag, req_idx, {LINE_OFF_W{1'b0}}};
          mem_wdata_d = '0;
        end
      end
      ST_REFILL: begin
        if (mem_ready) begin
          state_d     = ST_IDLE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dcache_wb.sv
// Bench for dcache_wb: directed scenarios plus random loads/stores checked
// against a line-level cache model and a backing-memory model.
module tb_dcache_wb;

  localparam int DW         = 32;
  localparam int LW         = 4;
  localparam int SETS       = 64;
  localparam int AW         = 32;
  localparam int BEW        = DW / 8;
  localparam int LINE_W     = LW * DW;
  localparam int LINE_BYTES = LW * DW / 8;
  localparam int TXN_W      = 1 + AW + LINE_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              re = 1'b0, we = 1'b0;
  logic [BEW-1:0]    be = '0;
  logic [AW-1:0]     addr = '0;
  logic [DW-1:0]     wdata = '0;
  logic [DW-1:0]     rdata;
  logic              stall;
  logic              mem_req, mem_we;
  logic [AW-1:0]     mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata = '0;
  logic              mem_ready = 1'b0;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: cache contents per set and the backing memory by line.
  bit                m_valid [SETS];
  bit                m_dirty [SETS];
  int unsigned       m_tag   [SETS];
  logic [LINE_W-1:0] m_line  [SETS];
  logic [LINE_W-1:0] bmem [int unsigned];
  // Expected memory transactions: {we, addr, wdata}.
  logic [TXN_W-1:0]  exp_q[$];

  dcache_wb #(.DATA_W(DW), .LINE_WORDS(LW), .SETS(SETS), .ADDR_W(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .re       (re),
    .we       (we),
    .be       (be),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .stall    (stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [LINE_W-1:0] get_line(input int unsigned la);
    if (!bmem.exists(la)) bmem[la] = {$urandom(), $urandom(), $urandom(), $urandom()};
    return bmem[la];
  endfunction

  task automatic clear_model();
    for (int s = 0; s < SETS; s++) begin
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
    end
  endtask

  // One CPU access; fix_delay < 0 picks random mem_ready latencies.
  task automatic cpu_access(input logic r, input logic w, input logic [AW-1:0] a,
                            input logic [BEW-1:0] b, input logic [DW-1:0] d,
                            input int fix_delay);
    int unsigned      line_a, idx, tg, woff;
    bit               miss, active, done;
    int               exp_stall, n_stall, dly, waited;
    logic [TXN_W-1:0] t;
    logic [DW-1:0]    exp_rd;
    line_a = a / LINE_BYTES;
    idx    = line_a % SETS;
    tg     = line_a / SETS;
    woff   = (a / BEW) % LW;
    miss   = (r || w) && !(m_valid[idx] && m_tag[idx] == tg);
    exp_q.delete();
    if (miss) begin
      if (m_valid[idx] && m_dirty[idx])
        exp_q.push_back({1'b1, AW'((m_tag[idx] * SETS + idx) * LINE_BYTES), m_line[idx]});
      exp_q.push_back({1'b0, AW'(line_a * LINE_BYTES), {LINE_W{1'b0}}});
    end
    re = r; we = w; addr = a; be = b; wdata = d;
    exp_stall = miss ? 1 : 0;
    n_stall = 0; active = 0; done = 0; dly = 0; waited = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1;
        break;
      end
      n_stall++;
      if (mem_req) begin
        if (exp_q.size() == 0) check_eq("txn_extra", mem_req, 0);
        else begin
          t = exp_q[0];
          check_eq("mem_we", mem_we, t[TXN_W-1]);
          check_eq("mem_addr", mem_addr, t[LINE_W +: AW]);
          if (t[TXN_W-1]) check_eq("mem_wdata", mem_wdata, t[LINE_W-1:0]);
          if (!active) begin
            active = 1;
            waited = 0;
            dly = (fix_delay >= 0) ? fix_delay : $urandom_range(0, 2);
          end
          if (waited == dly) begin
            mem_ready = 1'b1;
            if (t[TXN_W-1]) bmem[t[LINE_W +: AW] / LINE_BYTES] = t[LINE_W-1:0];
            else mem_rdata = get_line(t[LINE_W +: AW] / LINE_BYTES);
            exp_stall += dly + 1;
            void'(exp_q.pop_front());
            active = 0;
          end else waited++;
        end
      end else begin
        // Noise on mem_ready while no request is outstanding.
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
    end
    check_eq("stall_release", done, 1);
    check_eq("stall_cycles", n_stall, exp_stall);
    check_eq("txn_left", exp_q.size(), 0);
    if (miss) begin
      m_line[idx]  = get_line(line_a);
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
    end
    exp_rd = (r && !w) ? m_line[idx][woff*DW +: DW] : '0;
    check_eq("rdata", rdata, exp_rd);
    check_eq("idle_mem_req", mem_req, 0);
    check_eq("idle_mem_addr", mem_addr, 0);
    check_eq("idle_mem_wdata", mem_wdata, 0);
    if (w) begin
      for (int k = 0; k < BEW; k++)
        if (b[k]) m_line[idx][woff*DW + k*8 +: 8] = d[k*8 +: 8];
      m_dirty[idx] = 1'b1;
    end
    @(posedge clk);
    #1;
    re = 1'b0;
    we = 1'b0;
  endtask

  // Start a load miss, reset during its REFILL with mem_ready also high.
  task automatic reset_mid_refill(input logic [AW-1:0] a);
    bit seen;
    seen = 0;
    re = 1'b1; we = 1'b0; addr = a; be = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_req && !mem_we) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check_eq("rst_refill_seen", seen, 1);
    check_eq("rst_refill_addr", mem_addr, (a / LINE_BYTES) * LINE_BYTES);
    reset = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_ready = 1'b0;
    re = 1'b0;
    @(negedge clk);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_stall", stall, 0);
    check_eq("rst_rdata", rdata, 0);
    clear_model();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [AW-1:0] ra;
    int            pick;
    int unsigned   idx_pool [5];
    idx_pool = '{0, 1, 2, SETS - 2, SETS - 1};
    clear_model();
    bmem[32'h40 / LINE_BYTES] = {32'h4, 32'h3, 32'h2, 32'h1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_mem_req", mem_req, 0);
    check_eq("reset_mem_we", mem_we, 0);
    check_eq("reset_stall", stall, 0);
    check_eq("reset_rdata", rdata, 0);
    check_eq("reset_mem_addr", mem_addr, 0);
    check_eq("reset_mem_wdata", mem_wdata, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    cpu_access(1, 0, 32'h40, '0, '0, 0);
    cpu_access(1, 0, 32'h4C, '0, '0, -1);
    cpu_access(0, 1, 32'h44, 4'b0011, 32'hAAAABBBB, -1);
    cpu_access(1, 0, 32'h44, '0, '0, -1);
    cpu_access(1, 0, 32'h40 + SETS * LINE_BYTES, '0, '0, 0);
    cpu_access(1, 0, 32'h2060, '0, '0, 5);
    reset_mid_refill(32'h1050);
    cpu_access(1, 0, 32'h1050, '0, '0, -1);
    cpu_access(1, 1, 32'h1054, 4'hF, 32'h12345678, -1);
    cpu_access(1, 0, 32'h1054, '0, '0, -1);
    cpu_access(0, 1, 32'h3F4, 4'b1100, 32'hCAFEF00D, -1);
    cpu_access(1, 0, 32'h3F0 + SETS * LINE_BYTES, '0, '0, -1);
    cpu_access(1, 0, 32'h3F4, '0, '0, -1);

    for (int i = 0; i < 400; i++) begin
      pick = $urandom_range(0, 4);
      ra = AW'(((($urandom_range(0, 3) * SETS) + idx_pool[pick]) * LW
                + $urandom_range(0, LW - 1)) * BEW + $urandom_range(0, BEW - 1));
      case ($urandom_range(0, 9))
        0:          cpu_access(0, 0, ra, '0, '0, -1);
        1:          cpu_access(1, 1, ra, 4'($urandom()), $urandom(), -1);
        2, 3, 4:    cpu_access(0, 1, ra, 4'($urandom()), $urandom(), -1);
        default:    cpu_access(1, 0, ra, '0, '0, -1);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dcache_wb.md
# dcache_wb

Parametrised, direct-mapped, write-back data cache with a line-wide memory port. It replaces the flat single-cycle data RAM on the CPU data port. Hits complete in the same cycle as before: combinational read data, store on the clock edge. Misses raise `stall` while the block evicts any dirty victim and refills the line through a request/ready handshake to backing memory.

## Interface
- `DATA_W`, 32, word width in bits; must be a multiple of 8.
- `LINE_WORDS`, 4, words per line; power of two ≥ 2.
- `SETS`, 64, number of lines; power of two.
- `ADDR_W`, 32, byte address width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `re`  in  1  CPU load request.
- `we`  in  1  CPU store request; takes priority over `re` when both are high.
- `be`  in  DATA_W/8  store byte enables.
- `addr`  in  ADDR_W  byte address; the low log2(DATA_W/8) bits are ignored.
- `wdata`  in  DATA_W  store data.
- `rdata`  out  DATA_W  load data, combinational; 0 when `re`=0 or on a miss.
- `stall`  out  1  CPU must hold `re`/`we`/`addr`/`be`/`wdata` stable while high.
- `mem_req`  out  1  memory transaction valid.
- `mem_we`  out  1  1 = line write-back, 0 = line refill.
- `mem_addr`  out  ADDR_W  line-aligned byte address.
- `mem_wdata`  out  LINE_WORDS*DATA_W  victim line, word 0 in the LSBs.
- `mem_rdata`  in  LINE_WORDS*DATA_W  refill line, word 0 in the LSBs.
- `mem_ready`  in  1  completes the current transaction.

## Operation
- Address split (LSB→MSB): byte offset, word offset (log2 LINE_WORDS), index (log2 SETS), tag (remaining bits).
- Per line state: valid bit, dirty bit, tag, data.
- Hit = (`re`|`we`) & valid[index] & (tag match).
- State machine:
  - IDLE: on a load hit, drive `rdata`. On a store hit, write the enabled bytes at the clock edge and set dirty.
  - IDLE miss, victim valid & dirty: go to WRITEBACK.
  - IDLE miss otherwise: go to REFILL.
  - WRITEBACK: `mem_req`=1, `mem_we`=1, `mem_addr`={victim tag, index, 0}, `mem_wdata`=victim line. On `mem_ready`, go to REFILL.
  - REFILL: `mem_req`=1, `mem_we`=0, `mem_addr`={req tag, index, 0}. On `mem_ready`, write the line from `mem_rdata`, set valid=1, dirty=0 and the new tag, then go to IDLE.
- The replayed access hits in IDLE on the next cycle. A store replay merges its bytes and sets dirty.
- `stall` = (state≠IDLE) | ((`re`|`we`) & ~hit).
- A load with `re`=0 and `we`=0 never starts a miss.
- Reset clears all valid and dirty bits, forces IDLE and deasserts `mem_req`. Data and tag arrays are not cleared.

## Timing
- Reset values: `mem_req`=0, `mem_we`=0, `stall`=0, `rdata`=0. `mem_addr`=0 and `mem_wdata`=0 while idle.
- Hit latency: 0 cycles, no stall.
- Clean miss with `mem_ready` on the first request cycle: stall for 2 cycles (miss-detect, REFILL), hit on the 3rd.
- Dirty miss with immediate ready: stall for 3 cycles.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are registered or state-derived. They stay stable from assertion until the cycle `mem_ready` is sampled high.
- `mem_ready` is ignored while `mem_req`=0.
- Write-back and refill are never overlapped. Each transaction completes on exactly one `mem_ready` cycle.
- Reset asserted mid-WRITEBACK or mid-REFILL: the transaction is abandoned, and `mem_req`=0 from the next cycle. A `mem_ready` arriving in the reset cycle is ignored.
- Index wrap: the last set (index SETS-1) behaves identically to set 0; there are no special cases.

## Structure
- Shared package `dcache_pkg`: state encoding (IDLE, WRITEBACK, REFILL) and localparams for offset, index and tag widths derived from the parameters.
- One sub-module, `dcache_tag_array`: valid/dirty/tag storage with synchronous clear on `reset`, a combinational lookup port and one write port.
- Data storage and the FSM live in `dcache_wb`.

## Test plan
- Reset, then `re`=1 at `addr`=0x40 with LINE_WORDS=4 → `stall`=1 and `mem_req`=1, `mem_we`=0, `mem_addr`=0x40. Return ready with line {0x4,0x3,0x2,0x1} → the next cycle has `stall`=0 and `rdata`=0x1. Then `addr`=0x4C → `rdata`=0x4 with no stall.
- Store hit at 0x44, `be`=4'b0011, `wdata`=0xAAAABBBB over 0x2 → a following read of 0x44 returns 0x0000BBBB with no memory traffic.
- Dirty eviction: after the store above, read 0x40+SETS*16 → WRITEBACK first with `mem_addr`=0x40 and word 1 of `mem_wdata`=0x0000BBBB, then REFILL with `mem_addr`=0x40+SETS*16.
- Hold `mem_ready` low for 5 cycles during REFILL → `mem_req` and `mem_addr` stay stable and `stall` stays high. No array update occurs until ready.
- Assert `reset` mid-REFILL → `mem_req`=0 the next cycle, and a re-read of the same address misses again.
- `re`=`we`=1 on a hit → the access is treated as a store and `rdata`=0.
